// File: rtl/lldma_stream_downsizer.sv
// lldma_stream_downsizer: splits wide stream words into LSB-first narrow segments
module lldma_stream_downsizer #(
  parameter int IN_WIDTH = 512,
  parameter int RATIO = 4,
  localparam int OUT_WIDTH = IN_WIDTH / RATIO,
  localparam int SEG_W = $clog2(RATIO + 1)
) (
  input  logic                 user_clk,
  input  logic                 reset_n,
  input  logic                 tvalid_in,
  input  logic [IN_WIDTH-1:0]  tdata_in,
  input  logic [SEG_W-1:0]     tsegs_in,
  output logic                 tready_in,
  output logic                 tvalid_out,
  output logic [OUT_WIDTH-1:0] tdata_out,
  output logic                 tlast_out,
  input  logic                 tready_out,
  output logic                 err_oversize
);
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [SEG_W-1:0] RATIO_S = SEG_W'(RATIO);
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold_q, hold_d;
  logic hold_valid_q, hold_valid_d, err_q, err_d;
  logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d, nseg_q, nseg_d;
  logic in_xfer, out_xfer, last_xfer;
  assign tvalid_out = hold_valid_q;
  assign tdata_out = hold_q[seg_cnt_q[IDX_W-1:0]];
  assign tlast_out = hold_valid_q & (seg_cnt_q == nseg_q - SEG_W'(1));
  assign out_xfer = hold_valid_q & tready_out;
  assign last_xfer = out_xfer & tlast_out;
  assign tready_in = ~hold_valid_q | last_xfer;
  assign in_xfer = tvalid_in & tready_in;
  assign err_oversize = err_q;
  // load a new word on input transfer, otherwise step through its segments
  always_comb begin
    hold_d = in_xfer ? tdata_in : hold_q;
    hold_valid_d = in_xfer | (hold_valid_q & ~last_xfer);
    seg_cnt_d = (in_xfer | last_xfer) ? '0 : out_xfer ? seg_cnt_q + SEG_W'(1) : seg_cnt_q;
    nseg_d = ~in_xfer ? nseg_q : (tsegs_in == '0 || tsegs_in > RATIO_S) ? RATIO_S : tsegs_in;
    err_d = err_q | (in_xfer & (tsegs_in > RATIO_S));
  end
  // state registers, cleared asynchronously
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      seg_cnt_q <= '0;
      nseg_q <= '0;
      err_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
      seg_cnt_q <= seg_cnt_d;
      nseg_q <= nseg_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_lldma_stream_downsizer.sv
// tb_lldma_stream_downsizer: queue-model check of the stream downsizer
module tb_lldma_stream_downsizer;
  localparam int IN_WIDTH = 512;
  localparam int RATIO = 4;
  localparam int OUT_WIDTH = 128;
  localparam int SEG_W = 3;
  typedef struct {logic [OUT_WIDTH-1:0] d; logic l;} seg_t;
  typedef struct {logic [IN_WIDTH-1:0] d; logic [SEG_W-1:0] s;} word_t;
  logic user_clk = 1'b0;
  logic reset_n = 1'b0;
  logic tvalid_in = 1'b0;
  logic [IN_WIDTH-1:0] tdata_in = '0;
  logic [SEG_W-1:0] tsegs_in = '0;
  logic tready_out = 1'b0;
  logic tready_in, tvalid_out, tlast_out, err_oversize;
  logic [OUT_WIDTH-1:0] tdata_out;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  seg_t exp_q[$];
  word_t src_q[$];
  bit rdy_q[$];
  logic [OUT_WIDTH-1:0] log_d[$];
  logic log_l[$];
  int log_t[$];
  logic err_exp = 1'b0;
  lldma_stream_downsizer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .user_clk(user_clk), .reset_n(reset_n), .tvalid_in(tvalid_in), .tdata_in(tdata_in),
    .tsegs_in(tsegs_in), .tready_in(tready_in), .tvalid_out(tvalid_out), .tdata_out(tdata_out),
    .tlast_out(tlast_out), .tready_out(tready_out), .err_oversize(err_oversize)
  );
  always #5 user_clk = ~user_clk;
  task automatic chk(string n, logic [OUT_WIDTH-1:0] a, logic [OUT_WIDTH-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", n, a, e, $time);
    end
  endtask
  function automatic word_t mk(logic [31:0] b, logic [SEG_W-1:0] s);
    word_t w;
    w.d = {OUT_WIDTH'(b + 3), OUT_WIDTH'(b + 2), OUT_WIDTH'(b + 1), OUT_WIDTH'(b)};
    w.s = s;
    return w;
  endfunction
  task automatic drive();
    tvalid_in = src_q.size() > 0;
    tdata_in = src_q.size() > 0 ? src_q[0].d : '0;
    tsegs_in = src_q.size() > 0 ? src_q[0].s : '0;
    tready_out = rdy_q.size() > 0 ? rdy_q.pop_front() : 1'b1;
  endtask
  task automatic step();
    bit ox, ix;
    int n;
    @(posedge user_clk);
    cyc++;
    ox = exp_q.size() > 0 && tready_out;
    ix = tvalid_in && (exp_q.size() == 0 || (exp_q.size() == 1 && ox));
    if (ox) begin
      log_d.push_back(exp_q[0].d);
      log_l.push_back(exp_q[0].l);
      log_t.push_back(cyc);
      void'(exp_q.pop_front());
    end
    if (ix) begin
      n = (src_q[0].s == 0 || src_q[0].s > RATIO) ? RATIO : int'(src_q[0].s);
      if (src_q[0].s > RATIO) err_exp = 1'b1;
      for (int k = 0; k < n; k++) exp_q.push_back('{src_q[0].d[k*OUT_WIDTH +: OUT_WIDTH], k == n - 1});
      void'(src_q.pop_front());
    end
    #1;
    drive();
  endtask
  task automatic drain();
    int b = 0;
    drive();
    while ((src_q.size() > 0 || exp_q.size() > 0) && b < 200) begin
      step();
      b++;
    end
    chk("drain_timeout", b < 200, 1);
  endtask
  // every cycle out of reset the DUT must match the segment queue model
  always @(negedge user_clk) begin
    if (reset_n) begin
      chk("tvalid_out", tvalid_out, exp_q.size() > 0);
      chk("tready_in", tready_in, exp_q.size() == 0 || (exp_q.size() == 1 && tready_out));
      chk("err_oversize", err_oversize, err_exp);
      if (exp_q.size() > 0) begin
        chk("tdata_out", tdata_out, exp_q[0].d);
        chk("tlast_out", tlast_out, exp_q[0].l);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int l0;
    #1;
    chk("rst_tvalid_out", tvalid_out, 0);
    chk("rst_tdata_out", tdata_out, 0);
    chk("rst_tlast_out", tlast_out, 0);
    chk("rst_tready_in", tready_in, 1);
    chk("rst_err", err_oversize, 0);
    repeat (2) @(posedge user_clk);
    #1 reset_n = 1'b1;
    l0 = log_d.size();
    src_q.push_back(mk(0, 0));
    src_q.push_back(mk(4, 0));
    drain();
    for (int k = 0; k < 8; k++) chk("b2b_data", log_d[l0+k], k);
    chk("b2b_last3", log_l[l0+3], 1);
    chk("b2b_last2", log_l[l0+2], 0);
    chk("b2b_last7", log_l[l0+7], 1);
    chk("b2b_gap", log_t[l0+7] - log_t[l0], 7);
    l0 = log_d.size();
    src_q.push_back(mk(32'h10, 2));
    src_q.push_back(mk(32'h20, 0));
    drain();
    chk("part_seg0", log_d[l0], 32'h10);
    chk("part_seg1", log_d[l0+1], 32'h11);
    chk("part_last", log_l[l0+1], 1);
    chk("part_next", log_d[l0+2], 32'h20);
    l0 = log_d.size();
    src_q.push_back(mk(32'h30, 4));
    src_q.push_back(mk(32'h40, 1));
    rdy_q = '{1, 1, 0, 0, 1};
    drain();
    for (int k = 0; k < 4; k++) chk("bp_data", log_d[l0+k], 32'h30 + k);
    chk("bp_span", log_t[l0+3] - log_t[l0], 5);
    chk("bp_next", log_d[l0+4], 32'h40);
    l0 = log_d.size();
    for (int k = 0; k < 4; k++) src_q.push_back(mk(32'h50 + 16 * k, 1));
    drain();
    for (int k = 0; k < 4; k++) begin
      chk("single_data", log_d[l0+k], 32'h50 + 16 * k);
      chk("single_last", log_l[l0+k], 1);
    end
    chk("single_span", log_t[l0+3] - log_t[l0], 3);
    l0 = log_d.size();
    src_q.push_back(mk(32'h60, 5));
    drain();
    chk("over_count", log_d.size() - l0, 4);
    chk("over_seg3", log_d[l0+3], 32'h63);
    chk("over_last", log_l[l0+3], 1);
    chk("over_flag", err_oversize, 1);
    l0 = log_d.size();
    src_q.push_back(mk(32'h70, 0));
    drive();
    for (int b = 0; b < 20 && log_d.size() < l0 + 2; b++) step();
    chk("rstmid_progress", log_d.size() - l0, 2);
    reset_n = 1'b0;
    src_q.delete();
    exp_q.delete();
    err_exp = 1'b0;
    drive();
    #1;
    chk("rstmid_tvalid_out", tvalid_out, 0);
    chk("rstmid_tready_in", tready_in, 1);
    chk("rstmid_tdata_out", tdata_out, 0);
    chk("rstmid_err", err_oversize, 0);
    @(posedge user_clk);
    #1 reset_n = 1'b1;
    l0 = log_d.size();
    src_q.push_back(mk(32'h80, 0));
    drain();
    chk("rstmid_restart", log_d[l0], 32'h80);
    chk("rstmid_count", log_d.size() - l0, 4);
    repeat (2) @(posedge user_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
